// File: rtl/imem_load_ctrl_pkg.sv
// rtl/imem_load_ctrl_pkg.sv - shared state encoding and constants for the instruction-memory loader
package imem_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_READY = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_load_ctrl_assembler.sv
// rtl/imem_load_ctrl_assembler.sv - little-endian byte-to-word assembler with a one-cycle word-ready strobe
module byte_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_data,
    output logic        word_ready
);

    logic [1:0] lane;
    logic       accept;

    assign accept = enable && byte_valid && !clear;

    // Bytes shift in from the top, so after four the first byte sits in bits 7:0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= 2'd0;
            word_data  <= 32'd0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= accept && (lane == 2'd3);
            if (clear) begin
                lane <= 2'd0;
            end else if (accept) begin
                lane      <= lane + 2'd1;
                word_data <= {byte_data, word_data[31:8]};
            end
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - program loader and run/step/halt sequencer for the instruction memory
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic              i_step,
    input  logic              i_halt,
    input  logic              i_clear,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_pc_enable,
    output logic [2:0]        o_state,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_done,
    output logic              o_overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              step_q;
    logic              step_edge;
    logic              word_ready;
    logic [31:0]       word_data;

    byte_word_assembler u_assembler (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .clear      (i_clear),
        .enable     (state == ST_LOAD),
        .byte_valid (i_rx_valid),
        .byte_data  (i_rx_data),
        .word_data  (word_data),
        .word_ready (word_ready)
    );

    assign step_edge   = i_step && !step_q;
    assign o_mem_we    = word_ready;
    assign o_mem_addr  = ptr;
    assign o_mem_wdata = word_data;
    assign o_state     = state;
    assign o_done      = (state == ST_DONE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_LOAD;
            ptr          <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
            o_pc_enable  <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            step_q      <= i_step;
            o_pc_enable <= 1'b0;
            if (i_clear) begin
                state        <= ST_LOAD;
                ptr          <= '0;
                o_word_count <= '0;
                o_overflow   <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        // A write is on the bus this cycle; retire it and decide whether loading ends.
                        if (word_ready) begin
                            o_word_count <= o_word_count + CNT_ONE;
                            if (ptr != LAST_ADDR) begin
                                ptr <= ptr + PTR_ONE;
                            end
                            if (word_data == HALT_WORD) begin
                                state <= ST_READY;
                            end else if (ptr == LAST_ADDR) begin
                                o_overflow <= 1'b1;
                                state      <= ST_READY;
                            end
                        end
                    end
                    ST_READY: begin
                        if (i_start) begin
                            state       <= i_mode ? ST_STEP : ST_RUN;
                            o_pc_enable <= !i_mode;
                        end
                    end
                    ST_RUN: begin
                        if (i_halt) begin
                            state <= ST_DONE;
                        end else begin
                            o_pc_enable <= 1'b1;
                        end
                    end
                    ST_STEP: begin
                        // Halt beats a coincident step edge.
                        if (i_halt) begin
                            state <= ST_DONE;
                        end else begin
                            o_pc_enable <= step_edge;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - self-checking bench for imem_load_ctrl (default and 4-word instances)
module tb_imem_load_ctrl;
    import imem_load_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid, start, mode, step, halt, clear;
    logic [7:0] rx_data;

    logic        we0, pc0, done0, ovf0;
    logic [7:0]  addr0;
    logic [31:0] wdata0;
    logic [2:0]  state0;
    logic [8:0]  cnt0;

    logic        we1, pc1, done1, ovf1;
    logic [1:0]  addr1;
    logic [31:0] wdata1;
    logic [2:0]  state1;
    logic [2:0]  cnt1;

    imem_load_ctrl dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_start(start), .i_mode(mode), .i_step(step), .i_halt(halt), .i_clear(clear),
        .o_mem_we(we0), .o_mem_addr(addr0), .o_mem_wdata(wdata0), .o_pc_enable(pc0),
        .o_state(state0), .o_word_count(cnt0), .o_done(done0), .o_overflow(ovf0)
    );

    imem_load_ctrl #(.ADDR_W(2)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_start(start), .i_mode(mode), .i_step(step), .i_halt(halt), .i_clear(clear),
        .o_mem_we(we1), .o_mem_addr(addr1), .o_mem_wdata(wdata1), .o_pc_enable(pc1),
        .o_state(state1), .o_word_count(cnt1), .o_done(done1), .o_overflow(ovf1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: program bytes collected per word, pending write, sequencer state.
    int          depth [2] = '{256, 4};
    logic [2:0]  m_state [2];
    int          m_ptr [2];
    int          m_cnt [2];
    int          m_lane [2];
    bit          m_ovf [2];
    bit          m_pc [2];
    bit          m_we [2];
    logic [31:0] m_word [2];
    logic [31:0] m_wdata [2];
    bit          m_prev_step;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev_step = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_state[k] = ST_LOAD; m_ptr[k] = 0; m_cnt[k] = 0; m_lane[k] = 0;
                m_ovf[k] = 0; m_pc[k] = 0; m_we[k] = 0; m_word[k] = 0; m_wdata[k] = 0;
            end
        end else begin
            bit stp_edge;
            stp_edge = step && !m_prev_step;
            m_prev_step = step;
            for (int k = 0; k < 2; k++) begin
                bit nwe;
                nwe = 1'b0;
                m_pc[k] = 1'b0;
                if (clear) begin
                    m_state[k] = ST_LOAD; m_ptr[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_lane[k] = 0;
                end else begin
                    case (m_state[k])
                        ST_LOAD: begin
                            if (m_we[k]) begin
                                m_cnt[k]++;
                                if (m_wdata[k] == 32'hFFFF_FFFF) m_state[k] = ST_READY;
                                else if (m_ptr[k] == depth[k] - 1) begin
                                    m_ovf[k] = 1'b1;
                                    m_state[k] = ST_READY;
                                end
                                if (m_ptr[k] < depth[k] - 1) m_ptr[k]++;
                            end
                            if (rx_valid) begin
                                m_word[k][8*m_lane[k] +: 8] = rx_data;
                                if (m_lane[k] == 3) begin
                                    nwe = 1'b1;
                                    m_wdata[k] = m_word[k];
                                end
                                m_lane[k] = (m_lane[k] + 1) % 4;
                            end
                        end
                        ST_READY: if (start) begin
                            m_state[k] = mode ? ST_STEP : ST_RUN;
                            m_pc[k] = !mode;
                        end
                        ST_RUN:  if (halt) m_state[k] = ST_DONE; else m_pc[k] = 1'b1;
                        ST_STEP: if (halt) m_state[k] = ST_DONE; else m_pc[k] = stp_edge;
                        default: ;
                    endcase
                end
                m_we[k] = nwe;
            end
        end
    end

    task automatic cmp(int k, logic [2:0] st, logic we, logic [31:0] addr, logic [31:0] wd,
                       logic pc, logic [31:0] cnt, logic dn, logic ov);
        check($sformatf("i%0d_state", k), 64'(st), 64'(m_state[k]));
        check($sformatf("i%0d_we", k), 64'(we), 64'(m_we[k]));
        check($sformatf("i%0d_pc_enable", k), 64'(pc), 64'(m_pc[k]));
        check($sformatf("i%0d_word_count", k), 64'(cnt), 64'(m_cnt[k]));
        check($sformatf("i%0d_done", k), 64'(dn), 64'(m_state[k] == ST_DONE));
        check($sformatf("i%0d_overflow", k), 64'(ov), 64'(m_ovf[k]));
        if (m_we[k]) begin
            check($sformatf("i%0d_addr", k), 64'(addr), 64'(m_ptr[k]));
            check($sformatf("i%0d_wdata", k), 64'(wd), 64'(m_wdata[k]));
        end
    endtask

    int          log_a0[$], log_a1[$];
    logic [31:0] log_d0[$], log_d1[$];
    int          pc_cnt0 = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, state0, we0, 32'(addr0), wdata0, pc0, 32'(cnt0), done0, ovf0);
            cmp(1, state1, we1, 32'(addr1), wdata1, pc1, 32'(cnt1), done1, ovf1);
            if (we0) begin log_a0.push_back(int'(addr0)); log_d0.push_back(wdata0); end
            if (we1) begin log_a1.push_back(int'(addr1)); log_d1.push_back(wdata1); end
            if (pc0) pc_cnt0++;
        end
    end

    task automatic cyc();
        @(negedge clk);
        rx_valid = 1'b0; start = 1'b0; clear = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b);
        cyc();
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send_bytes(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    endtask

    task automatic clear_logs();
        log_a0.delete(); log_d0.delete(); log_a1.delete(); log_d1.delete();
    endtask

    initial begin
        rst_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;
        mode = 1'b0; step = 1'b0; halt = 1'b0; clear = 1'b0;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        cyc(); cyc();
        #2;
        check("rst_state", 64'(state0), 64'(ST_LOAD));
        check("rst_we", 64'(we0), 64'd0);
        check("rst_addr", 64'(addr0), 64'd0);
        check("rst_wdata", 64'(wdata0), 64'd0);
        check("rst_pc", 64'(pc0), 64'd0);
        check("rst_cnt", 64'(cnt0), 64'd0);
        check("rst_done_ovf", 64'({done0, ovf0}), 64'd0);
        cyc();
        rst_n = 1'b1;

        // Two-word program ending in the halt word
        send_bytes(8'h13, 8'h00, 8'h01, 8'h20);
        cyc();
        send_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) cyc();
        #2;
        check("load_nwrites", 64'(log_d0.size()), 64'd2);
        check("load_w0", 64'(log_d0[0]), 64'h2001_0013);
        check("load_a0", 64'(log_a0[0]), 64'd0);
        check("load_w1", 64'(log_d0[1]), 64'hFFFF_FFFF);
        check("load_a1", 64'(log_a0[1]), 64'd1);
        check("load_ready", 64'(state0), 64'(ST_READY));
        check("load_count", 64'(cnt0), 64'd2);
        send_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) cyc();
        #2;
        check("ready_ignores_rx", 64'(log_d0.size()), 64'd2);

        // Continuous run, halt during the fifth enabled cycle
        mode = 1'b0;
        pc_cnt0 = 0;
        cyc(); start = 1'b1;
        repeat (4) cyc();
        cyc(); halt = 1'b1;
        cyc(); halt = 1'b0;
        repeat (2) cyc();
        #2;
        check("run_pc_cycles", 64'(pc_cnt0), 64'd5);
        check("run_done", 64'(done0), 64'd1);
        cyc(); start = 1'b1;
        repeat (2) cyc();
        #2;
        check("done_ignores_start", 64'(state0), 64'(ST_DONE));

        // Single step: held step, two toggles, then halt with a coincident edge
        cyc(); clear = 1'b1;
        send_bytes(8'h01, 8'h00, 8'h00, 8'h00);
        send_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) cyc();
        mode = 1'b1;
        cyc(); start = 1'b1;
        cyc(); cyc();
        pc_cnt0 = 0;
        cyc(); step = 1'b1;
        repeat (4) cyc();
        step = 1'b0;
        cyc(); step = 1'b1;
        cyc(); step = 1'b0;
        cyc(); step = 1'b1;
        cyc(); step = 1'b0;
        repeat (3) cyc();
        #2;
        check("step_pulses", 64'(pc_cnt0), 64'd3);
        cyc(); step = 1'b1; halt = 1'b1;
        cyc(); step = 1'b0; halt = 1'b0;
        repeat (2) cyc();
        #2;
        check("step_halt_no_pulse", 64'(pc_cnt0), 64'd3);
        check("step_halt_done", 64'(state0), 64'(ST_DONE));

        // Fill the 4-word instance without a halt word
        cyc(); clear = 1'b1;
        #2 clear_logs();
        repeat (16) send_byte(8'h00);
        repeat (3) cyc();
        #2;
        check("ovf_nwrites", 64'(log_a1.size()), 64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("ovf_addr%0d", i), 64'(log_a1[i]), 64'(i));
        check("ovf_flag", 64'(ovf1), 64'd1);
        check("ovf_ready", 64'(state1), 64'(ST_READY));
        check("ovf_count", 64'(cnt1), 64'd4);
        check("ovf_ptr_held", 64'(addr1), 64'd3);
        check("big_no_ovf", 64'(ovf0), 64'd0);

        // Clear while running
        send_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) cyc();
        mode = 1'b0;
        cyc(); start = 1'b1;
        repeat (3) cyc();
        #2;
        check("run_before_clear", 64'(pc0), 64'd1);
        cyc(); clear = 1'b1;
        cyc();
        #2;
        check("clear_pc", 64'(pc0), 64'd0);
        check("clear_state", 64'(state0), 64'(ST_LOAD));
        check("clear_count", 64'(cnt0), 64'd0);
        check("clear_ovf", 64'(ovf1), 64'd0);

        // Reset in the middle of a word
        send_byte(8'hAA); send_byte(8'hBB);
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        #2 clear_logs();
        send_bytes(8'h44, 8'h33, 8'h22, 8'h11);
        repeat (3) cyc();
        #2;
        check("rst_mid_nwrites", 64'(log_d0.size()), 64'd1);
        check("rst_mid_word", 64'(log_d0[0]), 64'h1122_3344);
        check("rst_mid_addr", 64'(log_a0[0]), 64'd0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the instruction encoding that terminates a program.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a program byte.
REQ-006 i_rx_data  in  8  program byte, little-endian within each word.
REQ-007 i_start  in  1  one-cycle pulse: begin execution of the loaded program.
REQ-008 i_mode  in  1  sampled with i_start: 0 continuous run, 1 single step.
REQ-009 i_step  in  1  step request, level input, edge-detected internally.
REQ-010 i_halt  in  1  halt indication from the fetch stage (instruction memory halt signal).
REQ-011 i_clear  in  1  one-cycle pulse: discard program, return to loading.
REQ-012 o_mem_we  out  1  instruction-memory write strobe.
REQ-013 o_mem_addr  out  ADDR_W  instruction-memory write word address.
REQ-014 o_mem_wdata  out  32  instruction word being written.
REQ-015 o_pc_enable  out  1  pipeline/PC advance enable; also drives the memory fetch valid.
REQ-016 o_state  out  3  current state encoding, for debug.
REQ-017 o_word_count  out  ADDR_W+1  number of words written since last load start.
REQ-018 o_done  out  1  high while in DONE.
REQ-019 o_overflow  out  1  sticky: memory filled without HALT_WORD.

Function
REQ-020 States SHALL be LOAD, READY, RUN, STEP, DONE; reset state LOAD.
REQ-021 In LOAD, each i_rx_valid byte SHALL fill byte lane 0..3 in order (first byte = bits 7:0); a 2-bit byte counter wraps 3->0.
REQ-022 When the 4th byte is accepted in cycle N, o_mem_we SHALL be high for exactly cycle N+1 with o_mem_addr = write pointer and o_mem_wdata = assembled word; the pointer and o_word_count SHALL increment at the end of N+1.
REQ-023 If the written word equals HALT_WORD, the state SHALL go READY after the write cycle.
REQ-024 If the write targets address 2^ADDR_W-1 and the word is not HALT_WORD, the write SHALL occur, o_overflow SHALL set, and the state SHALL go READY; the pointer SHALL not wrap.
REQ-025 i_rx_valid outside LOAD SHALL be ignored; no write strobes outside LOAD.
REQ-026 In READY, i_start SHALL move to RUN (i_mode=0) or STEP (i_mode=1) on the next edge; o_pc_enable stays low in READY.
REQ-027 In RUN, o_pc_enable SHALL be high every cycle until i_halt is sampled high, then go DONE with o_pc_enable low from the next cycle.
REQ-028 In STEP, each rising edge of i_step (0 in previous cycle, 1 now) SHALL produce o_pc_enable high for exactly one cycle, the cycle after detection; a held i_step produces one pulse only.
REQ-029 i_halt and a step edge in the same cycle: halt SHALL win, no enable pulse, go DONE.
REQ-030 DONE SHALL hold until i_clear; i_start in DONE SHALL be ignored.
REQ-031 i_clear in any state SHALL go LOAD next cycle, zeroing pointer, byte counter, o_word_count, o_overflow; i_clear has priority over all other inputs.

Reset
REQ-032 Asserting i_reset_n low SHALL immediately force LOAD, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_pc_enable=0, o_word_count=0, o_done=0, o_overflow=0, byte counter 0, step edge register 0.
REQ-033 Reset mid-load SHALL discard any partial word; no write is issued on reset release.

Structure
REQ-034 State encoding and the default HALT_WORD constant SHALL reside in a shared package.
REQ-035 Byte-to-word assembly (lane counter, shift register, word-ready strobe) SHALL be a sub-module named byte_word_assembler; FSM and pointer stay in imem_load_ctrl.

Verification
REQ-036 Bytes 13,00,01,20 then FF x4 -> writes 32'h2001_0013 @0, 32'hFFFF_FFFF @1; READY; o_word_count=2.
REQ-037 ADDR_W=2, 16 bytes of 8'h00 -> 4 writes @0..3, o_overflow=1, READY, pointer not wrapped.
REQ-038 Loaded program, i_start with i_mode=0, i_halt after 5 cycles -> o_pc_enable high 5 cycles, then DONE, o_done=1.
REQ-039 i_mode=1, i_step held high 4 cycles, then toggled twice -> exactly 3 single-cycle o_pc_enable pulses; i_halt coincident with a step edge -> no pulse, DONE.
REQ-040 i_reset_n low after 2 bytes of a word, then 4 new bytes -> single write of the new word at address 0.
REQ-041 i_clear during RUN -> o_pc_enable low next cycle, state LOAD, counters and o_overflow zero.
